irq_reg: RTL and testbench

Memory-mapped, edge-triggered interrupt controller on the SERV SoC data bus (Wishbone-style, cyc/we/ack).
- Latches rising edges on REG_WIDTH interrupt inputs into a pending (state) register, gated by a per-line enable.
- Drives a single irq line to the CPU.
- Software reads raw inputs and pending bits, acknowledges pending bits, and sets/clears enables.

---
 rtl/irq_reg.sv | 117 +++++++++++
 tb/tb_irq_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_reg.sv
// irq_reg: edge-triggered interrupt controller on a Wishbone-style data bus.
// Ports: wb_clk/wb_rst (async active-low); wb_dbus_adr/dat/we/cyc in, ack/rdt out;
//        irq_in[REG_WIDTH] request lines in, irq out to the CPU.
// Latency: ack and rdt are registered one cycle after select. Without IRQ_SYNC_EN,
//          a rising irq_in sets state at the next edge. With IRQ_SYNC_EN, a
//          2-flop synchronizer adds 2 cycles to state and SIGNAL.
module irq_reg #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] ADDR      = 8'h00,
    parameter int                REG_WIDTH = 8
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [31:0]          wb_dbus_adr,
    input  logic [31:0]          wb_dbus_dat,
    input  logic                 wb_dbus_we,
    input  logic                 wb_dbus_cyc,
    output logic                 ack,
    output logic [31:0]          rdt,
    input  logic [REG_WIDTH-1:0] irq_in,
    output logic                 irq
);

    localparam logic [2:0] OFF_ENABLE = 3'd0;
    localparam logic [2:0] OFF_STATE  = 3'd1;
    localparam logic [2:0] OFF_ACK    = 3'd2;
    localparam logic [2:0] OFF_SIGNAL = 3'd3;
    localparam logic [2:0] OFF_SET_EN = 3'd4;
    localparam logic [2:0] OFF_CLR_EN = 3'd5;

    logic [REG_WIDTH-1:0] enable;
    logic [REG_WIDTH-1:0] state;
    logic [REG_WIDTH-1:0] prev;
    logic [REG_WIDTH-1:0] signal;
    logic [REG_WIDTH-1:0] rise;
    logic [REG_WIDTH-1:0] wdat;
    logic [REG_WIDTH-1:0] ack_clr;
    logic [2:0]           offset;
    logic                 sel;
    logic                 wr;
    logic                 rd;
    logic [31:0]          rd_mux;

    // Address bits below the offset and between offset and decode field are
    // deliberately ignored; fold them here so they count as consumed.
    logic unused_bus;
    assign unused_bus = ^{wb_dbus_adr, wb_dbus_dat};

    assign sel    = wb_dbus_cyc && (wb_dbus_adr[31:32-ADDR_W] == ADDR);
    assign offset = wb_dbus_adr[4:2];
    // Side effects happen only on the edge where ack rises, so a held cyc
    // performs one access per ack pulse.
    assign wr     = sel && !ack && wb_dbus_we;
    assign rd     = sel && !ack && !wb_dbus_we;
    assign wdat   = wb_dbus_dat[REG_WIDTH-1:0];

`ifdef IRQ_SYNC_EN
    logic [REG_WIDTH-1:0] sync_q1;
    logic [REG_WIDTH-1:0] sync_q2;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign signal = sync_q2;
`else
    assign signal = irq_in;
`endif

    assign rise    = signal & ~prev;
    assign ack_clr = (wr && offset == OFF_ACK) ? wdat : '0;

    always_comb begin
        rd_mux = 32'd0;
        case (offset)
            OFF_ENABLE: rd_mux = 32'(enable);
            OFF_STATE:  rd_mux = 32'(state);
            OFF_SIGNAL: rd_mux = 32'(signal);
            default:    rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            ack    <= 1'b0;
            rdt    <= 32'd0;
            enable <= '0;
            state  <= '0;
            prev   <= '0;
        end else begin
            ack  <= sel && !ack;
            rdt  <= rd ? rd_mux : 32'd0;
            prev <= signal;
            // Clear first, then set: a new edge wins over a same-cycle ACK.
            // The edge is qualified by the enable as it stood before any
            // write this cycle, so enabling a line already high sets nothing.
            state <= (state & ~ack_clr) | (rise & enable);
            if (wr) begin
                case (offset)
                    OFF_ENABLE: enable <= wdat;
                    OFF_SET_EN: enable <= enable | wdat;
                    OFF_CLR_EN: enable <= enable & ~wdat;
                    default:    enable <= enable;
                endcase
            end
        end
    end

    assign irq = |(state & enable);

endmodule

// File: tb/tb_irq_reg.sv
module tb_irq_reg;

    logic        wb_clk;
    logic        wb_rst;
    logic [31:0] wb_dbus_adr;
    logic [31:0] wb_dbus_dat;
    logic        wb_dbus_we;
    logic        wb_dbus_cyc;
    logic        ack;
    logic [31:0] rdt;
    logic [7:0]  irq_in;
    logic        irq;

    int checks = 0;
    int fails  = 0;

    irq_reg #(.ADDR_W(8), .ADDR(8'h00), .REG_WIDTH(8)) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .wb_dbus_adr (wb_dbus_adr),
        .wb_dbus_dat (wb_dbus_dat),
        .wb_dbus_we  (wb_dbus_we),
        .wb_dbus_cyc (wb_dbus_cyc),
        .ack         (ack),
        .rdt         (rdt),
        .irq_in      (irq_in),
        .irq         (irq)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge wb_clk);
    endtask

    // One bus access; inputs change at the falling edge, outputs sampled there.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       output logic [31:0] rd);
        wb_dbus_cyc = 1'b1;
        wb_dbus_we  = we;
        wb_dbus_adr = adr;
        wb_dbus_dat = dat;
        tick();
        for (int n = 0; n < 4 && ack !== 1'b1; n++) tick();
        check("ack_seen", {31'd0, ack}, 32'd1);
        rd = rdt;
        if (we) check("rdt_on_write_ack", rdt, 32'd0);
        wb_dbus_cyc = 1'b0;
        wb_dbus_we  = 1'b0;
        tick();
        check("ack_single_pulse", {31'd0, ack}, 32'd0);
        check("rdt_idle", rdt, 32'd0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        bus(1'b1, adr, dat, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, adr, 32'd0, v);
        check(tag, v, exp);
    endtask

    initial begin
        int seen;
        wb_rst      = 1'b0;
        wb_dbus_adr = 32'd0;
        wb_dbus_dat = 32'd0;
        wb_dbus_we  = 1'b0;
        wb_dbus_cyc = 1'b0;
        irq_in      = 8'h00;
        tick();
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_rdt", rdt, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        wb_rst = 1'b1;
        tick();

        // Enable lines 1..3
        wr(32'h00, 32'h0E);
        rd_check("enable_0e", 32'h00, 32'h0E);
        rd_check("state_zero", 32'h04, 32'h00);
        check("irq_idle", {31'd0, irq}, 32'd0);

        // Edges on enabled lines
        irq_in = 8'h02; tick();
        rd_check("signal_02", 32'h0C, 32'h02);
        rd_check("state_02", 32'h04, 32'h02);
        check("irq_line1", {31'd0, irq}, 32'd1);
        irq_in = 8'h0A; tick();
        rd_check("signal_0a", 32'h0C, 32'h0A);
        rd_check("state_0a", 32'h04, 32'h0A);
        irq_in = 8'h02; tick();
        rd_check("signal_drop3", 32'h0C, 32'h02);
        rd_check("state_kept", 32'h04, 32'h0A);

        // Acknowledge
        wr(32'h08, 32'h08);
        rd_check("state_after_ack8", 32'h04, 32'h02);
        check("irq_still", {31'd0, irq}, 32'd1);
        wr(32'h08, 32'h02);
        rd_check("state_after_ack2", 32'h04, 32'h00);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd_check("signal_level_held", 32'h0C, 32'h02);
        rd_check("ack_reg_reads0", 32'h08, 32'h00);

        // Edge on disabled line is discarded
        irq_in = 8'h01; tick();
        rd_check("signal_01", 32'h0C, 32'h01);
        rd_check("state_disabled_edge", 32'h04, 32'h00);
        wr(32'h10, 32'h01);
        rd_check("set_en", 32'h00, 32'h0F);
        check("irq_enable_high_line", {31'd0, irq}, 32'd0);
        wr(32'h14, 32'h0E);
        rd_check("clr_en", 32'h00, 32'h01);

        // Toggle line 0
        irq_in = 8'h00; tick();
        irq_in = 8'h01; tick(); tick();
        check("irq_toggle", {31'd0, irq}, 32'd1);
        wr(32'h14, 32'h01);
        check("irq_masked", {31'd0, irq}, 32'd0);
        rd_check("state_kept_masked", 32'h04, 32'h01);
        wr(32'h10, 32'h01);
        check("irq_reenabled", {31'd0, irq}, 32'd1);
        wr(32'h08, 32'h01);
        rd_check("state_acked", 32'h04, 32'h00);
        check("irq_after_ack", {31'd0, irq}, 32'd0);

        // Line 2 high before being enabled
        irq_in = 8'h05; tick();
        wr(32'h10, 32'h04);
        check("irq_late_enable", {31'd0, irq}, 32'd0);
        rd_check("state_late_enable", 32'h04, 32'h00);

        // Wrong top byte: never acked
        wb_dbus_cyc = 1'b1; wb_dbus_we = 1'b0; wb_dbus_adr = 32'h0100_0004;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (ack === 1'b1) seen++;
        end
        check("no_ack_wrong_addr", seen, 0);
        wb_dbus_cyc = 1'b0; tick();

        // Offsets 6/7 and address low bits
        rd_check("offset6_reads0", 32'h18, 32'h00);
        wr(32'h1C, 32'hFF);
        rd_check("offset7_write_ignored", 32'h03, 32'h05);
        wr(32'h18, 32'hFF);
        rd_check("offset6_write_ignored", 32'h00, 32'h05);

        // Rise and ACK on bit 0 in the same cycle: set wins
        irq_in = 8'h04; tick();
        irq_in = 8'h05; tick();
        irq_in = 8'h04; tick();
        irq_in = 8'h05;
        wr(32'h08, 32'h01);
        rd_check("set_beats_ack", 32'h04, 32'h01);
        wr(32'h08, 32'h01);
        rd_check("ack_no_rise", 32'h04, 32'h00);

        // Held cyc: ack on alternate cycles
        wb_dbus_cyc = 1'b1; wb_dbus_we = 1'b0; wb_dbus_adr = 32'h0C;
        tick(); check("held_ack0", {31'd0, ack}, 32'd1);
        check("held_rdt", rdt, 32'h05);
        tick(); check("held_ack1", {31'd0, ack}, 32'd0);
        check("held_rdt_gap", rdt, 32'd0);
        tick(); check("held_ack2", {31'd0, ack}, 32'd1);
        tick(); check("held_ack3", {31'd0, ack}, 32'd0);
        wb_dbus_cyc = 1'b0; tick();

        // Async reset mid-cycle
        irq_in = 8'h01; tick();
        irq_in = 8'h05; tick();
        check("irq_before_reset", {31'd0, irq}, 32'd1);
        wb_dbus_cyc = 1'b1; wb_dbus_we = 1'b0; wb_dbus_adr = 32'h04;
        #2 wb_rst = 1'b0;
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdt", rdt, 32'd0);
        tick();
        check("rst_no_ack", {31'd0, ack}, 32'd0);
        wb_dbus_cyc = 1'b0;
        wb_rst = 1'b1;
        tick();
        rd_check("rst_state", 32'h04, 32'h00);
        rd_check("rst_enable", 32'h00, 32'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
